// File: rtl/lcd_pkg.sv
// Shared types and helpers for the LCD pixel path: bpp codes, output formats,
// FSM state constants and per-mode pixel geometry.
package lcd_pkg;

  typedef enum logic [2:0] {
    Bpp1    = 3'b000,
    Bpp2    = 3'b001,
    Bpp4    = 3'b010,
    Bpp8    = 3'b011,
    Bpp1555 = 3'b100,
    Bpp24   = 3'b101,
    Bpp565  = 3'b110,
    Bpp444  = 3'b111
  } bpp_e;

  typedef enum logic [1:0] {
    Fmt1555,
    Fmt565,
    Fmt444,
    Fmt888
  } fmt_e;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StFill = 2'd1;
  localparam logic [1:0] StRun  = 2'd2;

  // Output pixel layout, shared with lcd_timing.
  localparam int unsigned LcdOutW = 24;
  localparam int unsigned LcdChanW = 8;

  function automatic logic [7:0] bpw_f(bpp_e bpp);
    logic [7:0] b;
    unique case (bpp)
      Bpp1:    b = 8'd1;
      Bpp2:    b = 8'd2;
      Bpp4:    b = 8'd4;
      Bpp8:    b = 8'd8;
      Bpp24:   b = 8'd24;
      default: b = 8'd16;
    endcase
    return b;
  endfunction

  // 24 bpp carries a single pixel per word regardless of word width.
  function automatic logic [7:0] ppw_f(bpp_e bpp, int unsigned word_w);
    if (bpp == Bpp24) return 8'd1;
    return 8'(word_w / 32'(bpw_f(bpp)));
  endfunction

  function automatic fmt_e fmt_f(bpp_e bpp);
    fmt_e f;
    unique case (bpp)
      Bpp565:  f = Fmt565;
      Bpp444:  f = Fmt444;
      Bpp24:   f = Fmt888;
      default: f = Fmt1555;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/lcd_pix_fmt.sv
// Combinational formatter: 16/24-bit source pixel to 8:8:8 RGB, optional R/B swap.
module lcd_pix_fmt
  import lcd_pkg::*;
(
  input  fmt_e        fmt,
  input  logic [23:0] pix,
  input  logic        bgr,
  output logic [23:0] rgb
);

  logic [23:0] f;

  always_comb begin
    unique case (fmt)
      Fmt1555: f = {pix[14:10], pix[15], 2'b00, pix[9:5], pix[15], 2'b00,
                    pix[4:0], pix[15], 2'b00};
      Fmt565:  f = {pix[15:11], 3'b000, pix[10:5], 2'b00, pix[4:0], 3'b000};
      Fmt444:  f = {pix[11:8], 4'h0, pix[7:4], 4'h0, pix[3:0], 4'h0};
      default: f = pix;
    endcase
    rgb = bgr ? {f[7:0], f[15:8], f[23:16]} : f;
  end

endmodule

// File: rtl/lcd_pixel_unpacker.sv
// Unpacks FIFO words into pixels, resolves indexed modes through the palette RAM
// and emits 24-bit RGB two hclk after each pix_ce.
module lcd_pixel_unpacker
  import lcd_pkg::*;
#(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned PAL_AW = 8,
  parameter int unsigned OUT_W  = 24
) (
  input  logic              hclk,
  input  logic              rst,
  input  logic              en,
  input  logic              pix_ce,
  input  logic [2:0]        bpp,
  input  logic              bebo,
  input  logic              bepo,
  input  logic              bgr,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              pal_rd,
  output logic [PAL_AW-1:0] pal_addr,
  input  logic [15:0]       pal_data,
  output logic [OUT_W-1:0]  lcd_dvd,
  output logic              lcd_valid,
  output logic              underflow
);

  logic [1:0]        state_q, state_d;
  logic [WORD_W-1:0] hold_q, hold_d, pre_q, pre_d;
  logic              pre_full_q, pre_full_d;
  logic [7:0]        pix_idx_q, pix_idx_d;

  bpp_e       mode;
  logic [7:0] b, ppw, kb, off;
  logic [1:0] order;
  logic       pal_mode, fire, last, accept;
  logic [23:0] mask, raw;

  assign mode     = bpp_e'(bpp);
  assign b        = bpw_f(mode);
  assign ppw      = ppw_f(mode, WORD_W);
  assign pal_mode = (b < 8'd16);
  // Reserved {bebo,bepo}=10 behaves as little-endian.
  assign order    = (bebo && !bepo) ? 2'b00 : {bebo, bepo};

  assign word_ready = en && !pre_full_q && (state_q != StIdle);
  assign accept     = word_valid && word_ready;
  assign fire       = en && pix_ce && (state_q == StRun);
  assign last       = (pix_idx_q == ppw - 8'd1);
  assign underflow  = en && pix_ce && (state_q == StFill);

  always_comb begin
    kb = pix_idx_q * b;
    if (mode == Bpp24) begin
      off = 8'd0;
    end else if (order == 2'b11) begin
      off = 8'(WORD_W) - b - kb;
    end else if (order == 2'b01 && b < 8'd8) begin
      off = {kb[7:3], 3'b000} + 8'd8 - b - {5'd0, kb[2:0]};
    end else begin
      off = kb;
    end
  end

  // Shifting a 1 out of range yields 0, so 24 bpp gets an all-ones mask.
  assign mask = (24'd1 << b) - 24'd1;
  assign raw  = 24'(hold_q >> off) & mask;

  assign pal_rd   = fire && pal_mode;
  assign pal_addr = pal_rd ? raw[PAL_AW-1:0] : '0;

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    pre_d      = pre_q;
    pre_full_d = pre_full_q;
    pix_idx_d  = pix_idx_q;
    if (!en) begin
      state_d    = StIdle;
      hold_d     = '0;
      pre_d      = '0;
      pre_full_d = 1'b0;
      pix_idx_d  = 8'd0;
    end else begin
      case (state_q)
        StIdle: state_d = StFill;
        StFill: begin
          if (accept) begin
            hold_d    = word_data;
            pix_idx_d = 8'd0;
            state_d   = StRun;
          end
        end
        StRun: begin
          if (fire && last) begin
            pix_idx_d = 8'd0;
            if (pre_full_q) begin
              hold_d     = pre_q;
              pre_full_d = 1'b0;
            end else if (accept) begin
              hold_d = word_data;
            end else begin
              state_d = StFill;
            end
          end else begin
            if (fire) pix_idx_d = pix_idx_q + 8'd1;
            if (accept) begin
              pre_d      = word_data;
              pre_full_d = 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge hclk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      hold_q     <= '0;
      pre_q      <= '0;
      pre_full_q <= 1'b0;
      pix_idx_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      pre_q      <= pre_d;
      pre_full_q <= pre_full_d;
      pix_idx_q  <= pix_idx_d;
    end
  end

  logic        s1_valid_q, s1_pal_q;
  logic [23:0] s1_raw_q, fmt_pix, rgb;
  fmt_e        fmt_sel;

  // Stage 1 formats either the palette entry read last cycle or the raw pixel.
  assign fmt_sel = s1_pal_q ? Fmt1555 : fmt_f(mode);
  assign fmt_pix = s1_pal_q ? {8'd0, pal_data} : s1_raw_q;

  lcd_pix_fmt u_fmt (
    .fmt (fmt_sel),
    .pix (fmt_pix),
    .bgr (bgr),
    .rgb (rgb)
  );

  always_ff @(posedge hclk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_pal_q   <= 1'b0;
      s1_raw_q   <= '0;
      lcd_valid  <= 1'b0;
      lcd_dvd    <= '0;
    end else begin
      s1_valid_q <= fire;
      s1_pal_q   <= pal_mode;
      if (fire) s1_raw_q <= raw;
      lcd_valid  <= s1_valid_q;
      if (s1_valid_q) lcd_dvd <= OUT_W'(rgb);
    end
  end

endmodule

// File: tb/tb_lcd_pixel_unpacker.sv
// Directed plus randomized bench for lcd_pixel_unpacker with a queue-based pixel model.
module tb_lcd_pixel_unpacker;

  logic        hclk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        pix_ce = 1'b0;
  logic [2:0]  bpp = 3'd0;
  logic        bebo = 1'b0;
  logic        bepo = 1'b0;
  logic        bgr = 1'b0;
  logic [31:0] word_data = 32'd0;
  logic        word_valid = 1'b0;
  logic        word_ready;
  logic        pal_rd;
  logic [7:0]  pal_addr;
  logic [15:0] pal_data = 16'd0;
  logic [23:0] lcd_dvd;
  logic        lcd_valid;
  logic        underflow;

  always #5 hclk = ~hclk;

  lcd_pixel_unpacker #(.WORD_W(32), .PAL_AW(8), .OUT_W(24)) dut (
    .hclk       (hclk),
    .rst        (rst),
    .en         (en),
    .pix_ce     (pix_ce),
    .bpp        (bpp),
    .bebo       (bebo),
    .bepo       (bepo),
    .bgr        (bgr),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .pal_rd     (pal_rd),
    .pal_addr   (pal_addr),
    .pal_data   (pal_data),
    .lcd_dvd    (lcd_dvd),
    .lcd_valid  (lcd_valid),
    .underflow  (underflow)
  );

  logic [15:0] pal_mem [256];
  always @(posedge hclk) if (pal_rd) pal_data <= pal_mem[pal_addr];

  typedef struct {
    logic [7:0]  idx;
    logic [23:0] rgb;
    bit          last;
  } pix_t;

  pix_t        pq[$];
  int          nwords = 0;
  bit          en_prev = 0;
  bit          ev1 = 0, ev2 = 0;
  logic [23:0] ed1 = '0, ed2 = '0;
  int          npass = 0, nfail = 0, nchk = 0, n_uf = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int bits_of(input logic [2:0] m);
    case (m)
      3'd0: return 1;
      3'd1: return 2;
      3'd2: return 4;
      3'd3: return 8;
      3'd5: return 24;
      default: return 16;
    endcase
  endfunction

  function automatic logic [23:0] ref_rgb(input int b, input int raw);
    int v, r, g, bl, t, i;
    v = (b <= 8) ? int'(pal_mem[raw]) : raw;
    if (b <= 8 || bpp == 3'd4) begin
      i = (v >> 15) & 1;
      r = ((v >> 10) & 31) * 8 + i * 4;
      g = ((v >> 5) & 31) * 8 + i * 4;
      bl = (v & 31) * 8 + i * 4;
    end else if (bpp == 3'd6) begin
      r = ((v >> 11) & 31) * 8;
      g = ((v >> 5) & 63) * 4;
      bl = (v & 31) * 8;
    end else if (bpp == 3'd7) begin
      r = ((v >> 8) & 15) * 16;
      g = ((v >> 4) & 15) * 16;
      bl = (v & 15) * 16;
    end else begin
      r = (v >> 16) & 255;
      g = (v >> 8) & 255;
      bl = v & 255;
    end
    if (bgr) begin
      t = r; r = bl; bl = t;
    end
    return 24'(r * 65536 + g * 256 + bl);
  endfunction

  task automatic push_word(input logic [31:0] wd);
    int b, ppw, ord, off, raw;
    b = bits_of(bpp);
    ppw = (bpp == 3'd5) ? 1 : 32 / b;
    ord = (bebo && !bepo) ? 0 : int'({bebo, bepo});
    for (int k = 0; k < ppw; k++) begin
      if (bpp == 3'd5) off = 0;
      else if (ord == 3) off = 32 - (k + 1) * b;
      else if (ord == 1 && b < 8) off = 8 * ((k * b) / 8) + 8 - b - (k * b) % 8;
      else off = k * b;
      raw = int'((longint'(wd) >> off) & ((longint'(1) << b) - 1));
      pq.push_back('{idx: 8'(raw), rgb: ref_rgb(b, raw), last: (k == ppw - 1)});
    end
    nwords++;
  endtask

  // One hclk: drive at +1, check at negedge, advance the model at posedge.
  task automatic cyc(input bit pce, input bit wv, input logic [31:0] wd);
    bit serv, acc;
    pix_t p;
    pix_ce = pce; word_valid = wv; word_data = wd;
    @(negedge hclk);
    serv = pce && en && (pq.size() > 0);
    chk("underflow", underflow, pce && en && en_prev && pq.size() == 0);
    if (underflow) n_uf++;
    chk("pal_rd", pal_rd, serv && bits_of(bpp) <= 8);
    if (serv && bits_of(bpp) <= 8) chk("pal_addr", pal_addr, pq[0].idx);
    chk("lcd_valid", lcd_valid, ev2);
    if (ev2) chk("lcd_dvd", lcd_dvd, ed2);
    if (en && en_prev) chk("word_ready", word_ready, nwords < 2);
    acc = wv && word_ready;
    @(posedge hclk);
    ev2 = ev1; ed2 = ed1;
    ev1 = serv; ed1 = serv ? pq[0].rgb : 24'd0;
    if (serv) begin
      p = pq.pop_front();
      if (p.last) nwords--;
    end
    if (!en) begin
      pq.delete(); nwords = 0;
    end else if (acc) begin
      push_word(wd);
    end
    en_prev = en;
    #1;
  endtask

  task automatic setup(input logic [2:0] bp, input logic be, input logic bo, input logic bg);
    en = 1'b0;
    repeat (3) cyc(0, 0, 32'd0);
    bpp = bp; bebo = be; bepo = bo; bgr = bg;
    en = 1'b1;
    cyc(0, 0, 32'd0);
  endtask

  task automatic feed(input logic [31:0] wd, input int npix);
    cyc(0, 1, wd);
    repeat (npix) cyc(1, 0, 32'd0);
    repeat (3) cyc(0, 0, 32'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_lcd_valid"}, lcd_valid, 0);
    chk({tag, "_lcd_dvd"}, lcd_dvd, 0);
    chk({tag, "_pal_rd"}, pal_rd, 0);
    chk({tag, "_pal_addr"}, pal_addr, 0);
    chk({tag, "_word_ready"}, word_ready, 0);
    chk({tag, "_underflow"}, underflow, 0);
  endtask

  int uf0;

  initial begin
    for (int i = 0; i < 256; i++) pal_mem[i] = 16'($urandom);
    pal_mem[0] = 16'h0000;
    pal_mem[1] = 16'h7FFF;
    #2;
    check_zero_outputs("reset");
    @(posedge hclk); #1;
    rst = 1'b0;

    // 1 bpp, little-endian
    setup(3'd0, 0, 0, 0);
    feed(32'h0000_0005, 32);

    // 8 bpp, each pixel order
    setup(3'd3, 0, 0, 0); feed(32'hDDCC_BBAA, 4);
    setup(3'd3, 0, 1, 0); feed(32'hDDCC_BBAA, 4);
    setup(3'd3, 1, 1, 0); feed(32'hDDCC_BBAA, 4);

    // 4 bpp, big-endian pixels within bytes
    setup(3'd2, 0, 1, 0); feed(32'h0000_0021, 8);

    // 5:6:5 with and without R/B swap
    setup(3'd6, 0, 0, 0); feed(32'h07E0_F800, 2);
    setup(3'd6, 0, 0, 1); feed(32'h07E0_F800, 2);

    // 24 bpp streaming at one pixel per hclk, then a 3-hclk supply gap
    setup(3'd5, 0, 0, 0);
    cyc(0, 1, $urandom);
    repeat (20) cyc(1, 1, $urandom);
    uf0 = n_uf;
    repeat (3) cyc(1, 0, 32'd0);
    repeat (10) cyc(1, 1, $urandom);
    chk("gap_underflows", n_uf - uf0, 3);
    repeat (3) cyc(0, 0, 32'd0);

    // Reset mid-word at 2 bpp
    setup(3'd1, 0, 0, 0);
    cyc(0, 1, $urandom);
    repeat (5) cyc(1, 1, $urandom);
    pix_ce = 1'b1; word_valid = 1'b1;
    rst = 1'b1;
    #1;
    check_zero_outputs("midrst");
    pq.delete(); nwords = 0; ev1 = 0; ev2 = 0; en_prev = 0;
    en = 1'b0; pix_ce = 1'b0; word_valid = 1'b0;
    @(posedge hclk); #1;
    rst = 1'b0;

    // Enable drop mid-word, then restart from pixel 0
    setup(3'd1, 0, 0, 0);
    cyc(0, 1, $urandom);
    repeat (5) cyc(1, 1, $urandom);
    en = 1'b0;
    repeat (4) cyc(1, 1, $urandom);
    en = 1'b1;
    cyc(0, 0, 32'd0);
    feed($urandom, 16);

    // Randomized sweep over all modes and orders
    for (int m = 0; m < 8; m++) begin
      for (int o = 0; o < 4; o++) begin
        setup(m[2:0], o[1], o[0], 1'($urandom % 2));
        for (int i = 0; i < 30; i++) cyc(($urandom % 4) != 0, 1'($urandom % 2), $urandom);
      end
    end
    en = 1'b0;
    repeat (3) cyc(0, 0, 32'd0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
